sram0_rr_arbiter: RTL and testbench
===================================

// Module: sram0_rr_arbiter
// PURPOSE
//   Shares one single-port sram0 instance (active-low en_n/wren_n, registered read data) between
//   two requesters: port A (compute engine, reads weights/activations) and port B (loader, writes).
//   Each port uses a valid/ready command handshake. A round-robin arbiter grants at most one
//   command per cycle, drives the SRAM pins, and returns read data to the issuing port with an ID tag.
// PARAMETERS
//   DATA_WIDTH  16  SRAM word width; must match the attached sram0
//   ADDR_WIDTH  5   SRAM address width; must match the attached sram0
// PORTS
//   clk          in   1           rising-edge clock, shared with sram0
//   rst          in   1           asynchronous, active-high reset
//   a_valid      in   1           port A command valid
//   a_ready      out  1           port A command accepted this cycle (grant)
//   a_we         in   1           1 = write, 0 = read
//   a_addr       in   ADDR_WIDTH  port A word address
//   a_wdata      in   DATA_WIDTH  port A write data
//   a_rvalid     out  1           port A read data valid
//   a_rdata      out  DATA_WIDTH  port A read data
//   b_valid/b_ready/b_we/b_addr/b_wdata/b_rvalid/b_rdata  same as port A, for port B
//   sram_en_n    out  1           to sram0 en_n
//   sram_wren_n  out  1           to sram0 wren_n
//   sram_addr    out  ADDR_WIDTH  to sram0 addr
//   sram_data_i  out  DATA_WIDTH  to sram0 data_i
//   sram_data_o  in   DATA_WIDTH  from sram0 data_o
// BEHAVIOUR
// - Handshake: a command transfers on the cycle where valid && ready. ready is combinational from
//   the valid inputs and the priority pointer. A requester holds valid, we, addr and wdata stable
//   until ready. A ready is never given while the same port's valid is low.
// - Arbitration: registered pointer `prio` (0 = A favoured, 1 = B favoured). Only one port valid:
//   that port is granted. Both ports valid: the favoured port is granted. After any grant, prio
//   moves to the non-granted port. An idle cycle leaves prio unchanged. Reset value of prio is 0.
// - SRAM drive, combinational in the grant cycle: sram_en_n = ~(a_ready|b_ready);
//   sram_wren_n = ~(grant & we of the granted port). sram_addr and sram_data_i are muxed from the
//   granted port. With no grant, sram_en_n=1, sram_wren_n=1, and addr/data are driven to 0.
// - Read response: a read granted in cycle N is sampled by sram0 at the end of N. rvalid for the
//   issuing port is asserted for exactly one cycle, in N+1, with rdata = sram_data_o. Read latency
//   is 1 cycle. Response tracking uses registered flags rd_pend and rd_id, both reset to 0.
//   Reads can be issued back-to-back at one per cycle. There is no backpressure on responses.
// - rdata of a port is 0 whenever that port's rvalid is 0.
// - Writes produce no response. A write granted in cycle N is visible to a read granted in N+1 or
//   later. Ordering across ports follows grant order, because the memory is single-port.
// - During rst, all outputs read as 0 except sram_en_n=1 and sram_wren_n=1: ready outputs are gated
//   by ~rst. If rst asserts mid-operation, any pending read response is discarded and no rvalid
//   appears after reset deasserts. prio returns to 0.
// - Commands are never dropped or duplicated. Address wrap is the SRAM's own modulo-2^ADDR_WIDTH.
// - Throughput: 1 command per cycle total. Under continuous dual request the ports strictly alternate.
// TESTING
// 1. Reset: assert rst with a_valid=b_valid=1 -> a_ready=b_ready=0, sram_en_n=1, sram_wren_n=1,
//    all rvalid=0. Deassert rst -> A is granted first (prio=0).
// 2. Single write/read: B writes 0xBEEF to addr 7. The next cycle, A reads addr 7 -> a_rvalid=1
//    exactly 1 cycle after a_ready, a_rdata=0xBEEF, b_rvalid stays 0.
// 3. Contention: both valid for 6 cycles, A reading addr 1..3, B writing addr 10..12 -> grants
//    alternate A,B,A,B,A,B. A receives 3 responses in order. The SRAM holds B's data at 10..12.
// 4. Back-to-back reads: preload addr 0..3 = 0x1000..0x1003. A reads 0..3 in consecutive cycles ->
//    a_rvalid is high for 4 consecutive cycles with data 0x1000..0x1003.
// 5. Reset mid-read: A is granted a read of addr 5, and rst asserts in the next cycle before the
//    edge -> a_rvalid never asserts. After release, prio=0 and normal operation resumes.
// 6. Fairness/idle: B alone valid for 3 cycles -> 3 grants. Then both valid -> A is granted first.
//    Hold A low -> B is granted every cycle. A random soak checks against a reference memory model.

Source files
------------

// File: rtl/sram0_rr_arbiter_if.sv
// Command/response bundle for one requester of the shared sram0 arbiter.
// The requester owns the command fields; the arbiter owns ready and the read response.
interface sram0_rr_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  valid;
  logic                  ready;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/sram0_rr_arbiter.sv
// Round-robin sharing of one single-port sram0 between requesters A and B,
// with one-cycle read responses routed back to the issuing port.
module sram0_rr_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  sram0_rr_arbiter_if.slave     a,
  sram0_rr_arbiter_if.slave     b,
  output logic                  sram_en_n,
  output logic                  sram_wren_n,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data_i,
  input  logic [DATA_WIDTH-1:0] sram_data_o
);

  typedef enum logic {
    FAV_A = 1'b0,
    FAV_B = 1'b1
  } prio_t;

  prio_t prio, prio_next;
  logic  grant_a, grant_b, grant, grant_we;
  logic  rd_pend, rd_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio    <= FAV_A;
      rd_pend <= 1'b0;
      rd_id   <= 1'b0;
    end else begin
      prio    <= prio_next;
      rd_pend <= grant & ~grant_we;
      if (grant) rd_id <= grant_b;
    end
  end

  // Grants are forced off during reset so no command can slip into the SRAM.
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    prio_next = prio;
    if (!rst) begin
      if (a.valid && (!b.valid || prio == FAV_A)) grant_a = 1'b1;
      else if (b.valid)                           grant_b = 1'b1;
    end
    if (grant_a)      prio_next = FAV_B;
    else if (grant_b) prio_next = FAV_A;
  end

  always_comb begin
    grant       = grant_a | grant_b;
    grant_we    = (grant_a & a.we) | (grant_b & b.we);
    sram_en_n   = ~grant;
    sram_wren_n = ~grant_we;
    sram_addr   = '0;
    sram_data_i = '0;
    if (grant_a) begin
      sram_addr   = a.addr;
      sram_data_i = a.wdata;
    end else if (grant_b) begin
      sram_addr   = b.addr;
      sram_data_i = b.wdata;
    end
  end

  always_comb begin
    a.ready  = grant_a;
    b.ready  = grant_b;
    a.rvalid = rd_pend & ~rd_id;
    b.rvalid = rd_pend & rd_id;
    a.rdata  = a.rvalid ? sram_data_o : '0;
    b.rdata  = b.rvalid ? sram_data_o : '0;
  end

endmodule

// File: tb/tb_sram0_rr_arbiter.sv
// Bench for sram0_rr_arbiter: directed scenarios plus a random soak, all cycles
// compared against a transaction-level model of arbitration and memory contents.
module tb_sram0_rr_arbiter;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst;
  logic          sram_en_n, sram_wren_n;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data_i;
  logic [DW-1:0] sram_data_o = '0;
  logic [DW-1:0] sram_mem [32] = '{default: '0};

  int n_tests = 0;
  int n_fail  = 0;

  sram0_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a_if ();
  sram0_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b_if ();

  sram0_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .a(a_if), .b(b_if),
    .sram_en_n(sram_en_n), .sram_wren_n(sram_wren_n),
    .sram_addr(sram_addr), .sram_data_i(sram_data_i), .sram_data_o(sram_data_o)
  );

  always #5 clk = ~clk;

  // Behavioural sram0: active-low enables, registered read data.
  always @(posedge clk) begin
    if (!sram_en_n) begin
      if (!sram_wren_n) sram_mem[sram_addr] <= sram_data_i;
      else              sram_data_o         <= sram_mem[sram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: who wins, what the pins carry, and what each read must return.
  logic [DW-1:0] ref_mem [32] = '{default: '0};
  bit            m_prio_b;
  bit            m_pend_a, m_pend_b;
  logic [DW-1:0] m_data;

  always @(negedge clk) begin
    bit ga, gb, gwe;
    logic [AW-1:0] gaddr;
    logic [DW-1:0] gdata;
    if (rst) begin
      chk("cmp_rst_a_ready", a_if.ready, 0);
      chk("cmp_rst_b_ready", b_if.ready, 0);
      chk("cmp_rst_en_n", sram_en_n, 1);
      chk("cmp_rst_wren_n", sram_wren_n, 1);
      chk("cmp_rst_addr", sram_addr, 0);
      chk("cmp_rst_data_i", sram_data_i, 0);
      chk("cmp_rst_a_rvalid", a_if.rvalid, 0);
      chk("cmp_rst_b_rvalid", b_if.rvalid, 0);
      chk("cmp_rst_a_rdata", a_if.rdata, 0);
      chk("cmp_rst_b_rdata", b_if.rdata, 0);
      m_prio_b = 0;
      m_pend_a = 0;
      m_pend_b = 0;
    end else begin
      ga    = a_if.valid && (!b_if.valid || !m_prio_b);
      gb    = b_if.valid && !ga;
      gwe   = ga ? a_if.we : (gb ? b_if.we : 1'b0);
      gaddr = ga ? a_if.addr : (gb ? b_if.addr : '0);
      gdata = ga ? a_if.wdata : (gb ? b_if.wdata : '0);
      chk("cmp_a_ready", a_if.ready, ga);
      chk("cmp_b_ready", b_if.ready, gb);
      chk("cmp_en_n", sram_en_n, !(ga || gb));
      chk("cmp_wren_n", sram_wren_n, !gwe);
      chk("cmp_addr", sram_addr, gaddr);
      chk("cmp_data_i", sram_data_i, gdata);
      chk("cmp_a_rvalid", a_if.rvalid, m_pend_a);
      chk("cmp_b_rvalid", b_if.rvalid, m_pend_b);
      chk("cmp_a_rdata", a_if.rdata, m_pend_a ? m_data : '0);
      chk("cmp_b_rdata", b_if.rdata, m_pend_b ? m_data : '0);
      m_pend_a = ga && !gwe;
      m_pend_b = gb && !gwe;
      if ((ga || gb) && !gwe) m_data = ref_mem[gaddr];
      if ((ga || gb) && gwe)  ref_mem[gaddr] = gdata;
      if (ga)      m_prio_b = 1;
      else if (gb) m_prio_b = 0;
    end
  end

  task automatic drive(input logic av, input logic aw, input int aa, input int ad,
                       input logic bv, input logic bw, input int ba, input int bd);
    a_if.valid = av; a_if.we = aw; a_if.addr = AW'(aa); a_if.wdata = DW'(ad);
    b_if.valid = bv; b_if.we = bw; b_if.addr = AW'(ba); b_if.wdata = DW'(bd);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_b(input int addr, input int data);
    @(posedge clk); #1 drive(0, 0, 0, 0, 1, 1, addr, data);
    @(negedge clk); chk("wr_b_ready", b_if.ready, 1);
    @(posedge clk); #1 idle();
  endtask

  task automatic rd_a(input int addr, input int exp);
    @(posedge clk); #1 drive(1, 0, addr, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rd_a_ready", a_if.ready, 1);
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("rd_a_rvalid", a_if.rvalid, 1);
    chk("rd_a_rdata", a_if.rdata, exp);
  endtask

  initial begin
    logic [DW-1:0] got[$];
    int ai, bi;
    bit acc_a, acc_b;

    // Reset with both requesters asking.
    rst = 1;
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_a_ready", a_if.ready, 0);
    chk("rst_b_ready", b_if.ready, 0);
    chk("rst_en_n", sram_en_n, 1);
    chk("rst_wren_n", sram_wren_n, 1);
    chk("rst_a_rvalid", a_if.rvalid, 0);
    chk("rst_b_rvalid", b_if.rvalid, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("first_grant_a", a_if.ready, 1);
    chk("first_grant_not_b", b_if.ready, 0);
    @(posedge clk); #1 idle();

    // B writes, A reads it back the following cycle.
    @(posedge clk); #1 drive(0, 0, 0, 0, 1, 1, 7, 'hBEEF);
    @(negedge clk);
    chk("b_wr_ready", b_if.ready, 1);
    chk("b_wr_wren_n", sram_wren_n, 0);
    chk("b_wr_addr", sram_addr, 7);
    chk("b_wr_data", sram_data_i, 'hBEEF);
    @(posedge clk); #1 drive(1, 0, 7, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("a_rd_ready", a_if.ready, 1);
    chk("a_rd_en_n", sram_en_n, 0);
    chk("a_rd_wren_n", sram_wren_n, 1);
    @(posedge clk); #1 idle();
    @(negedge clk);
    chk("a_rd_rvalid", a_if.rvalid, 1);
    chk("a_rd_rdata", a_if.rdata, 'hBEEF);
    chk("a_rd_b_rvalid", b_if.rvalid, 0);
    @(negedge clk);
    chk("a_rd_rvalid_once", a_if.rvalid, 0);
    chk("a_rd_rdata_zero", a_if.rdata, 0);

    // Contention: B preloads, then both hold requests for six grants.
    for (int i = 1; i <= 3; i++) wr_b(i, 'h0100 + i);
    ai = 0; bi = 0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1
      drive(ai < 3, 0, 1 + ai, 0, bi < 3, 1, 10 + bi, 'hB010 + bi);
      @(negedge clk);
      if (a_if.rvalid) got.push_back(a_if.rdata);
      if (c < 6) begin
        chk($sformatf("alt_a_ready_%0d", c), a_if.ready, (c % 2) == 0);
        chk($sformatf("alt_b_ready_%0d", c), b_if.ready, (c % 2) == 1);
      end
      if (a_if.ready) ai++;
      if (b_if.ready) bi++;
    end
    @(posedge clk); #1 idle();
    chk("alt_resp_count", got.size(), 3);
    for (int i = 0; i < got.size(); i++) chk($sformatf("alt_resp_%0d", i), got[i], 'h0101 + i);
    for (int i = 0; i < 3; i++) rd_a(10 + i, 'hB010 + i);

    // Back-to-back reads.
    for (int i = 0; i < 4; i++) wr_b(i, 'h1000 + i);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1
      if (c < 4) drive(1, 0, c, 0, 0, 0, 0, 0);
      else       idle();
      @(negedge clk);
      if (c < 4) chk($sformatf("b2b_ready_%0d", c), a_if.ready, 1);
      if (c > 0) begin
        chk($sformatf("b2b_rvalid_%0d", c), a_if.rvalid, 1);
        chk($sformatf("b2b_rdata_%0d", c), a_if.rdata, 'h1000 + c - 1);
      end
    end
    @(negedge clk);
    chk("b2b_rvalid_end", a_if.rvalid, 0);

    // Reset lands while a read is in flight.
    wr_b(5, 'h5555);
    @(posedge clk); #1 drive(1, 0, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rstmid_grant", a_if.ready, 1);
    #2 rst = 1;
    idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid_no_rvalid_%0d", c), a_if.rvalid, 0);
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rstmid_no_rvalid_after", a_if.rvalid, 0);
    @(posedge clk); #1 drive(1, 0, 5, 0, 1, 0, 6, 0);
    @(negedge clk);
    chk("rstmid_prio_a", a_if.ready, 1);
    chk("rstmid_prio_not_b", b_if.ready, 0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 1, 0, 6, 0);
    @(negedge clk);
    chk("rstmid_resume_rvalid", a_if.rvalid, 1);
    chk("rstmid_resume_rdata", a_if.rdata, 'h5555);
    chk("rstmid_b_next", b_if.ready, 1);
    @(posedge clk); #1 idle();

    // Fairness and idle behaviour.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1 drive(0, 0, 0, 0, 1, 1, 20 + c, 'h2000 + c);
      @(negedge clk);
      chk($sformatf("b_alone_%0d", c), b_if.ready, 1);
    end
    @(posedge clk); #1 drive(1, 0, 20, 0, 1, 1, 23, 'h2003);
    @(negedge clk);
    chk("both_a_first", a_if.ready, 1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1 drive(0, 0, 0, 0, 1, 1, 23 + c, 'h2003 + c);
      @(negedge clk);
      chk($sformatf("a_low_b_%0d", c), b_if.ready, 1);
    end
    @(posedge clk); #1 idle();

    // Random soak with handshake-respecting requesters and rare resets.
    acc_a = 0; acc_b = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1
      rst = ($urandom_range(0, 199) == 0);
      if (!a_if.valid || acc_a) begin
        a_if.valid = ($urandom_range(0, 3) != 0);
        a_if.we    = $urandom_range(0, 1);
        a_if.addr  = AW'($urandom);
        a_if.wdata = DW'($urandom);
      end
      if (!b_if.valid || acc_b) begin
        b_if.valid = ($urandom_range(0, 3) != 0);
        b_if.we    = $urandom_range(0, 1);
        b_if.addr  = AW'($urandom);
        b_if.wdata = DW'($urandom);
      end
      @(negedge clk);
      acc_a = a_if.valid && a_if.ready;
      acc_b = b_if.valid && b_if.ready;
    end
    @(posedge clk); #1 rst = 0; idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
